// File: rtl/uart_pkg.sv
// Shared register map, status bit positions and FSM state types for uart_ctrl.
package uart_pkg;

  localparam logic [2:0] UART_TX_DATA = 3'd0;
  localparam logic [2:0] UART_TX_STAT = 3'd1;
  localparam logic [2:0] UART_RX_DATA = 3'd2;
  localparam logic [2:0] UART_RX_STAT = 3'd3;
  localparam logic [2:0] UART_DIV     = 3'd4;
  localparam logic [2:0] UART_CTRL    = 3'd5;
  localparam logic [2:0] UART_ST      = 3'd6;

  localparam int unsigned ST_RXNE  = 0;
  localparam int unsigned ST_TXE   = 1;
  localparam int unsigned ST_RXOVF = 2;
  localparam int unsigned ST_FERR  = 3;
  localparam int unsigned ST_PERR  = 4;
  localparam int unsigned ST_TXOVF = 5;

  localparam logic [15:0] MIN_DIV = 16'd8;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

endpackage

// File: rtl/uart_ctrl_if.sv
// Single-cycle register bus shared by the memory-mapped peripherals.
interface uart_ctrl_if;
  logic        we;
  logic        re;
  logic [2:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output re, output a, output wd, input rd);
  modport slave  (input we, input re, input a, input wd, output rd);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push while full is accepted when a pop lands in the same cycle.
module uart_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  logic [DEPTH_LOG2:0] wp_q, rp_q;
  logic [WIDTH-1:0]    mem_q [2**DEPTH_LOG2];
  logic                do_push, do_pop;

  assign count_o = wp_q - rp_q;
  assign empty_o = (count_o == '0);
  assign full_o  = count_o[DEPTH_LOG2];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rp_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_ctrl.sv
// UART with TX/RX FIFOs, programmable divisor, optional even parity and maskable level IRQ.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 5,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  uart_ctrl_if.slave  bus,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        irq_o
);

  localparam int unsigned Depth = 2**DEPTH_LOG2;

  logic [15:0] div_q;
  logic [4:0]  ctrl_q;
  logic        rxovf_q, ferr_q, perr_q, txovf_q, irq_q;

  logic [7:0]          tx_rdata, rx_rdata;
  logic                tx_full, tx_empty, rx_full, rx_empty;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic                tx_push, tx_pop, rx_pop, rxne, txe, tx_busy;
  logic [5:0]          st_clr;

  tx_state_e   tx_state_q;
  logic [15:0] tx_cnt_q, tx_div_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_shift_q;
  logic        tx_par_q, tx_pen_q, tx_out_q;

  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q, rx_div_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_pen_q, rx_s1_q, rx_s2_q, rx_prev_q;
  logic        rx_push_q, rx_ferr_q, rx_perr_q;

  logic unused_wd;
  assign unused_wd = ^bus.wd[31:16];

  assign tx_push = bus.we && (bus.a == UART_TX_DATA);
  assign rx_pop  = bus.re && (bus.a == UART_RX_DATA) && !rx_empty;
  assign tx_pop  = !tx_empty &&
                   ((tx_state_q == TxIdle) || ((tx_state_q == TxStop) && (tx_cnt_q == '0)));
  assign st_clr  = (bus.we && (bus.a == UART_ST)) ? bus.wd[5:0] : 6'd0;
  assign rxne    = !rx_empty;
  assign txe     = tx_empty && (tx_state_q == TxIdle);
  assign tx_busy = !txe;

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push),
    .wdata_i (bus.wd[7:0]),
    .pop_i   (tx_pop),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  uart_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push_q),
    .wdata_i (rx_shift_q),
    .pop_i   (rx_pop),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      div_q   <= 16'(DEFAULT_DIV);
      ctrl_q  <= '0;
      rxovf_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      txovf_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (bus.we && (bus.a == UART_DIV)) begin
        div_q <= (bus.wd[15:0] < MIN_DIV) ? MIN_DIV : bus.wd[15:0];
      end
      if (bus.we && (bus.a == UART_CTRL)) ctrl_q <= bus.wd[4:0];
      // A new set in the same cycle as a W1C wins.
      rxovf_q <= (rxovf_q & ~st_clr[ST_RXOVF]) | (rx_push_q & rx_full & ~rx_pop);
      ferr_q  <= (ferr_q & ~st_clr[ST_FERR]) | rx_ferr_q;
      perr_q  <= (perr_q & ~st_clr[ST_PERR]) | rx_perr_q;
      txovf_q <= (txovf_q & ~st_clr[ST_TXOVF]) | (tx_push & tx_full & ~tx_pop);
      irq_q   <= (rxne & ctrl_q[1]) | (txe & ctrl_q[2]) | (rxovf_q & ctrl_q[3]) |
                 ((ferr_q | perr_q) & ctrl_q[4]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(DEFAULT_DIV);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pen_q   <= 1'b0;
      tx_out_q   <= 1'b1;
    end else begin
      if ((tx_state_q != TxIdle) && (tx_cnt_q != '0)) tx_cnt_q <= tx_cnt_q - 1'b1;
      case (tx_state_q)
        TxIdle, TxStop: begin
          if (tx_state_q == TxIdle || tx_cnt_q == '0) begin
            if (tx_pop) begin
              // Divisor and parity mode are latched per frame.
              tx_state_q <= TxStart;
              tx_div_q   <= div_q;
              tx_cnt_q   <= div_q - 1'b1;
              tx_shift_q <= tx_rdata;
              tx_par_q   <= ^tx_rdata;
              tx_pen_q   <= ctrl_q[0];
              tx_out_q   <= 1'b0;
            end else begin
              tx_state_q <= TxIdle;
              tx_out_q   <= 1'b1;
            end
          end
        end
        TxStart: if (tx_cnt_q == '0) begin
          tx_state_q <= TxData;
          tx_cnt_q   <= tx_div_q - 1'b1;
          tx_bit_q   <= '0;
          tx_out_q   <= tx_shift_q[0];
        end
        TxData: if (tx_cnt_q == '0) begin
          tx_cnt_q <= tx_div_q - 1'b1;
          if (tx_bit_q == 3'd7) begin
            tx_state_q <= tx_pen_q ? TxParity : TxStop;
            tx_out_q   <= tx_pen_q ? tx_par_q : 1'b1;
          end else begin
            tx_shift_q <= tx_shift_q >> 1;
            tx_out_q   <= tx_shift_q[1];
            tx_bit_q   <= tx_bit_q + 1'b1;
          end
        end
        TxParity: if (tx_cnt_q == '0) begin
          tx_state_q <= TxStop;
          tx_cnt_q   <= tx_div_q - 1'b1;
          tx_out_q   <= 1'b1;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'(DEFAULT_DIV);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_pen_q   <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_push_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_push_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
      if ((rx_state_q != RxIdle) && (rx_cnt_q != '0)) rx_cnt_q <= rx_cnt_q - 1'b1;
      case (rx_state_q)
        RxIdle: if (rx_prev_q && !rx_s2_q) begin
          rx_state_q <= RxStart;
          rx_div_q   <= div_q;
          rx_cnt_q   <= (div_q >> 1) - 1'b1;
          rx_pen_q   <= ctrl_q[0];
        end
        RxStart: if (rx_cnt_q == '0) begin
          // Line back high at mid-start means a glitch.
          rx_state_q <= rx_s2_q ? RxIdle : RxData;
          rx_cnt_q   <= rx_div_q - 1'b1;
          rx_bit_q   <= '0;
        end
        RxData: if (rx_cnt_q == '0) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_q   <= rx_div_q - 1'b1;
          rx_bit_q   <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_q <= rx_pen_q ? RxParity : RxStop;
        end
        RxParity: if (rx_cnt_q == '0) begin
          rx_perr_q  <= ^{rx_shift_q, rx_s2_q};
          rx_state_q <= RxStop;
          rx_cnt_q   <= rx_div_q - 1'b1;
        end
        RxStop: if (rx_cnt_q == '0) begin
          rx_state_q <= RxIdle;
          rx_push_q  <= rx_s2_q;
          rx_ferr_q  <= ~rx_s2_q;
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  always_comb begin
    bus.rd = '0;
    case (bus.a)
      UART_TX_STAT: bus.rd = {15'd0, tx_busy, 16'(Depth) - 16'(tx_count)};
      UART_RX_DATA: bus.rd = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_rdata};
      UART_RX_STAT: bus.rd = 32'(rx_count);
      UART_DIV:     bus.rd = {16'd0, div_q};
      UART_CTRL:    bus.rd = {27'd0, ctrl_q};
      UART_ST:      bus.rd = {26'd0, txovf_q, perr_q, ferr_q, rxovf_q, txe, rxne};
      default:      bus.rd = '0;
    endcase
  end

  assign uart_tx_o = tx_out_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl: TX framing, loopback, overflow, parity/framing errors, reset.
module tb_uart_ctrl;
  import uart_pkg::*;

  localparam int unsigned DivT = 16;

  logic clk, rst_n, uart_rx, uart_tx, irq, loop, rx_drv;
  int   n_checks, n_errors;

  uart_ctrl_if bus ();

  assign uart_rx = loop ? uart_tx : rx_drv;

  uart_ctrl #(.DEPTH_LOG2(2), .DEFAULT_DIV(434)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .uart_rx_i (uart_rx),
    .uart_tx_o (uart_tx),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.we = 1'b1; bus.a = addr; bus.wd = data;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd_now(input logic [2:0] addr, output logic [31:0] d);
    bus.a = addr;
    #1;
    d = bus.rd;
  endtask

  task automatic pop(output logic [31:0] d);
    @(negedge clk);
    bus.a = UART_RX_DATA; bus.re = 1'b1;
    #1;
    d = bus.rd;
    @(posedge clk);
    #1;
    bus.re = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    cycles(DivT);
  endtask

  task automatic rx_frame(input logic [7:0] data, input logic use_par, input logic par,
                          input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (use_par) drive_bit(par);
    drive_bit(stop);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_checks++;
    if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd_now(UART_DIV, d);
    n_checks++;
    if (d !== 32'd434) begin n_errors++; $display("FAIL reset_div: got %0d want 434", d); end
    rd_now(UART_TX_STAT, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL reset_txstat: got %h want 4", d); end
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_rxstat: got %h want 0", d); end
    cycles(1);
    rd_now(UART_ST, d);
    n_checks++;
    if (d !== 32'h2) begin n_errors++; $display("FAIL reset_st: got %h want 2", d); end
    rd_now(3'd7, d);
    n_checks++;
    if (d !== 32'h0) begin n_errors++; $display("FAIL reset_reg7: got %h want 0", d); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] d;
    logic [9:0]  frame;
    frame = {1'b1, 8'h55, 1'b0};
    wr(UART_TX_DATA, 32'h55);
    n_checks++;
    if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL tx_push_edge: got %b want 1", uart_tx); end
    cycles(1);
    n_checks++;
    if (uart_tx !== 1'b0) begin n_errors++; $display("FAIL tx_start_fall: got %b want 0", uart_tx); end
    cycles(433);
    n_checks++;
    if (uart_tx !== 1'b0) begin n_errors++; $display("FAIL tx_start_end: got %b want 0", uart_tx); end
    cycles(1);
    n_checks++;
    if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL tx_bit0_begin: got %b want 1", uart_tx); end
    cycles(217);
    for (int i = 1; i < 10; i++) begin
      n_checks++;
      if (uart_tx !== frame[i]) begin
        n_errors++; $display("FAIL tx_bit%0d: got %b want %b", i, uart_tx, frame[i]);
      end
      if (i < 9) cycles(434);
    end
    cycles(216);
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_TXE] !== 1'b0) begin n_errors++; $display("FAIL tx_txe_early: got %b want 0", d[ST_TXE]); end
    cycles(1);
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_TXE] !== 1'b1) begin n_errors++; $display("FAIL tx_txe_done: got %b want 1", d[ST_TXE]); end
    rd_now(UART_TX_STAT, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL tx_stat_idle: got %h want 4", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d;
    logic [31:0] exp [3];
    int          got;
    exp[0] = 32'h100; exp[1] = 32'h1FF; exp[2] = 32'h1A5;
    wr(UART_DIV, DivT);
    loop = 1'b1;
    wr(UART_TX_DATA, 32'h00);
    wr(UART_TX_DATA, 32'hFF);
    wr(UART_TX_DATA, 32'hA5);
    got = 0;
    for (int i = 0; i < 2000 && got < 3; i++) begin
      cycles(1);
      rd_now(UART_RX_STAT, d);
      got = int'(d[15:0]);
    end
    cycles(4 * DivT);
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd3) begin n_errors++; $display("FAIL loop_count: got %0d want 3", d); end
    for (int i = 0; i < 3; i++) begin
      pop(d);
      n_checks++;
      if (d !== exp[i]) begin n_errors++; $display("FAIL loop_data%0d: got %h want %h", i, d, exp[i]); end
    end
    rd_now(UART_RX_DATA, d);
    n_checks++;
    if (d[8] !== 1'b0) begin n_errors++; $display("FAIL loop_empty: got %b want 0", d[8]); end
    rd_now(UART_ST, d);
    n_checks++;
    if (d[5:2] !== 4'h0) begin n_errors++; $display("FAIL loop_err: got %h want 0", d[5:2]); end
    loop = 1'b0;
  endtask

  task automatic test_rx_overflow();
    logic [31:0] d;
    logic [7:0]  bytes [5];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    for (int i = 0; i < 5; i++) rx_frame(bytes[i], 1'b0, 1'b0, 1'b1);
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd4) begin n_errors++; $display("FAIL ovf_count: got %0d want 4", d); end
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_RXOVF] !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", d[ST_RXOVF]); end
    wr(UART_ST, 32'h04);
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_RXOVF] !== 1'b0) begin n_errors++; $display("FAIL ovf_w1c: got %b want 0", d[ST_RXOVF]); end
    for (int i = 0; i < 4; i++) begin
      pop(d);
      n_checks++;
      if (d !== {23'd0, 1'b1, bytes[i]}) begin
        n_errors++; $display("FAIL ovf_data%0d: got %h want %h", i, d, {23'd0, 1'b1, bytes[i]});
      end
    end
  endtask

  task automatic test_parity_ferr();
    logic [31:0] d;
    wr(UART_CTRL, 32'h1);
    rx_frame(8'h03, 1'b1, 1'b1, 1'b1);
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_PERR] !== 1'b1) begin n_errors++; $display("FAIL perr_flag: got %b want 1", d[ST_PERR]); end
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd1) begin n_errors++; $display("FAIL perr_stored: got %0d want 1", d); end
    rx_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    rd_now(UART_ST, d);
    n_checks++;
    if (d[ST_FERR] !== 1'b1) begin n_errors++; $display("FAIL ferr_flag: got %b want 1", d[ST_FERR]); end
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd1) begin n_errors++; $display("FAIL ferr_count: got %0d want 1", d); end
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_masked: got %b want 0", irq); end
    wr(UART_CTRL, 32'h11);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_latency: got %b want 0", irq); end
    cycles(1);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_err: got %b want 1", irq); end
    wr(UART_ST, 32'h18);
    wr(UART_CTRL, 32'h0);
    pop(d);
    n_checks++;
    if (d !== 32'h103) begin n_errors++; $display("FAIL perr_data: got %h want 103", d); end
    cycles(2);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
  endtask

  task automatic test_glitch_div();
    logic [31:0] d;
    rx_drv = 1'b0;
    cycles(2);
    rx_drv = 1'b1;
    cycles(4 * DivT);
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd0) begin n_errors++; $display("FAIL glitch_count: got %0d want 0", d); end
    rd_now(UART_ST, d);
    n_checks++;
    if (d[4:2] !== 3'd0) begin n_errors++; $display("FAIL glitch_err: got %h want 0", d[4:2]); end
    wr(UART_DIV, 32'd3);
    rd_now(UART_DIV, d);
    n_checks++;
    if (d !== 32'd8) begin n_errors++; $display("FAIL div_clamp: got %0d want 8", d); end
    wr(UART_DIV, DivT);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    rx_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wr(UART_CTRL, 32'h2);
    cycles(1);
    n_checks++;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_rxne: got %b want 1", irq); end
    wr(UART_TX_DATA, 32'hA5);
    wr(UART_TX_DATA, 32'h5A);
    cycles(5);
    n_checks++;
    if (uart_tx !== 1'b0) begin n_errors++; $display("FAIL mid_frame_low: got %b want 0", uart_tx); end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (uart_tx !== 1'b1) begin n_errors++; $display("FAIL rst_tx_high: got %b want 1", uart_tx); end
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL rst_irq: got %b want 0", irq); end
    rd_now(UART_RX_STAT, d);
    n_checks++;
    if (d !== 32'd0) begin n_errors++; $display("FAIL rst_rx_empty: got %0d want 0", d); end
    rd_now(UART_TX_STAT, d);
    n_checks++;
    if (d !== 32'h4) begin n_errors++; $display("FAIL rst_tx_empty: got %h want 4", d); end
    rd_now(UART_DIV, d);
    n_checks++;
    if (d !== 32'd434) begin n_errors++; $display("FAIL rst_div: got %0d want 434", d); end
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    rd_now(UART_ST, d);
    n_checks++;
    if (d !== 32'h2) begin n_errors++; $display("FAIL rst_st: got %h want 2", d); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    loop     = 1'b0;
    rx_drv   = 1'b1;
    bus.we   = 1'b0;
    bus.re   = 1'b0;
    bus.a    = '0;
    bus.wd   = '0;
    test_reset();
    test_tx_frame();
    test_loopback();
    test_rx_overflow();
    test_parity_ferr();
    test_glitch_div();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
